// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop input sync, mid-bit sampling,
// one-cycle data_valid / frame_err strobes and a busy flag.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RX,
  output logic [7:0] Data_RX,
  output logic       data_valid,
  output logic       frame_err,
  output logic       is_busy
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state;
  logic             rx_m, rx_s, wait_high;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sh;
  assign is_busy = state != IDLE;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      wait_high  <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      Data_RX    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= RX;
      rx_s       <= rx_m;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // after a bad stop bit the line must return high before re-arming
          if (rx_s) wait_high <= 1'b0;
          else if (!wait_high) state <= START;
        end
        START:
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL) begin
            cnt     <= '0;
            sh[idx] <= rx_s;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              Data_RX    <= sh;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
